// File: rtl/hazard_ctrl_pkg.sv
// Shared CPU parameters for the hazard unit: bypass select codes, Tuse
// "unused" marker, mult/div latencies and the MD state encoding.
// Pure definitions; no ports, no latency, no backpressure.
package hazard_ctrl_pkg;

   // Bypass mux select for a GPR read operand
   localparam logic [1:0] RData0_from_RData0 = 2'b00;  // register file
   localparam logic [1:0] RData0_from_ID     = 2'b01;  // ID/EX result
   localparam logic [1:0] RData0_from_EX     = 2'b10;  // EX/Mem result

   // Tuse value meaning "this source is not read"
   localparam logic [2:0] TUSE_UNUSED = 3'b111;

   // Mult/div occupancy in RUN cycles
   localparam logic [3:0] MULT_CYC = 4'd5;
   localparam logic [3:0] DIV_CYC  = 4'd10;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_RUN  = 1'b1
   } md_state_t;

endpackage

// File: rtl/hazard_ctrl_cmp.sv
// Per-source hazard compare: decides stall and bypass select for one GPR read.
// Latency: purely combinational (0 cycles).
// Backpressure: none; o_stall feeds the pipeline freeze in the parent.
// Ports: i_rreg/i_tuse  - source register and cycles until it is needed
//        i_waddr_*/i_tnew_* - destination and cycles-to-ready in ID/EX, EX/Mem
//        o_stall, o_bypass  - stall request and 2-bit bypass select
module hazard_cmp
   import hazard_ctrl_pkg::*;
(
   input  logic [4:0] i_rreg,
   input  logic [2:0] i_tuse,
   input  logic [4:0] i_waddr_ex,
   input  logic [2:0] i_tnew_ex,
   input  logic [4:0] i_waddr_mem,
   input  logic [2:0] i_tnew_mem,
   output logic       o_stall,
   output logic [1:0] o_bypass
);

   logic w_hit_ex;
   logic w_hit_mem;
   logic w_used;

   // r0 is hardwired zero: never a hazard, never forwarded
   assign w_hit_ex  = (i_rreg != 5'd0) && (i_waddr_ex  == i_rreg);
   assign w_hit_mem = (i_rreg != 5'd0) && (i_waddr_mem == i_rreg);
   // An unused source can never stall (Tnew is at most 7 anyway, kept explicit)
   assign w_used    = (i_tuse != TUSE_UNUSED);

   assign o_stall = w_used && ((w_hit_ex  && (i_tnew_ex  > i_tuse)) ||
                               (w_hit_mem && (i_tnew_mem > i_tuse)));

   // The ID/EX producer is younger, so its match shadows any EX/Mem match
   // even when its result is not ready yet.
   always_comb begin
      o_bypass = RData0_from_RData0;
      if (w_hit_ex) begin
         if (i_tnew_ex == 3'd0) o_bypass = RData0_from_ID;
      end else if (w_hit_mem && (i_tnew_mem == 3'd0)) begin
         o_bypass = RData0_from_EX;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: data-hazard stall, bypass selects, mult/div busy FSM.
// Latency: Stall/Busy/bypass are combinational; MD FSM advances once per clk.
// Backpressure: Stall freezes IF/ID and bubbles ID/EX; no inputs are held off.
// Ports: clk, reset (async, active-high); RegRead*/Tuse* of the ID instruction;
//        WAddr/Tnew of ID/EX and EX/Mem; MultTypeInstr, Start, MDDiv;
//        outputs Stall, RData0/1BypassCtrl, Busy, MDDone.
// Optional: HAZARD_STALL_CNT_EN adds 32-bit StallCount (stall cycles, wraps).
module hazard_ctrl
   import hazard_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] RegRead0_ID,
   input  logic [4:0] RegRead1_ID,
   input  logic [2:0] Tuse_RAddr0_ID,
   input  logic [2:0] Tuse_RAddr1_ID,
   input  logic [4:0] WAddr_EX,
   input  logic [2:0] Tnew_EX,
   input  logic [4:0] WAddr_Mem,
   input  logic [2:0] Tnew_Mem,
   input  logic       MultTypeInstr,
   input  logic       Start,
   input  logic       MDDiv,
   output logic       Stall,
   output logic [1:0] RData0BypassCtrl,
   output logic [1:0] RData1BypassCtrl,
`ifdef HAZARD_STALL_CNT_EN
   output logic [31:0] StallCount,
`endif
   output logic       Busy,
   output logic       MDDone
);

   md_state_t  r_state, w_state_nxt;
   logic [3:0] r_cnt, w_cnt_nxt;
   logic       w_stall0, w_stall1;

   hazard_cmp u_cmp0 (
      .i_rreg      (RegRead0_ID),
      .i_tuse      (Tuse_RAddr0_ID),
      .i_waddr_ex  (WAddr_EX),
      .i_tnew_ex   (Tnew_EX),
      .i_waddr_mem (WAddr_Mem),
      .i_tnew_mem  (Tnew_Mem),
      .o_stall     (w_stall0),
      .o_bypass    (RData0BypassCtrl)
   );

   hazard_cmp u_cmp1 (
      .i_rreg      (RegRead1_ID),
      .i_tuse      (Tuse_RAddr1_ID),
      .i_waddr_ex  (WAddr_EX),
      .i_tnew_ex   (Tnew_EX),
      .i_waddr_mem (WAddr_Mem),
      .i_tnew_mem  (Tnew_Mem),
      .o_stall     (w_stall1),
      .o_bypass    (RData1BypassCtrl)
   );

   // Start counts as busy in its own cycle so a following HI/LO user stalls
   assign Busy  = Start | (r_state == MD_RUN);
   assign Stall = (MultTypeInstr & Busy) | w_stall0 | w_stall1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= MD_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Start during RUN is ignored: the running operation keeps its count
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      MDDone      = 1'b0;
      case (r_state)
         MD_IDLE: begin
            if (Start) begin
               w_state_nxt = MD_RUN;
               w_cnt_nxt   = MDDiv ? DIV_CYC : MULT_CYC;
            end
         end
         MD_RUN: begin
            w_cnt_nxt = r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
               w_state_nxt = MD_IDLE;
               MDDone      = 1'b1;
            end
         end
         default: begin
            w_state_nxt = MD_IDLE;
            w_cnt_nxt   = 4'd0;
         end
      endcase
   end

`ifdef HAZARD_STALL_CNT_EN
   logic [31:0] r_stall_cnt;

   // Free-running; natural wrap from all-ones to zero
   always_ff @(posedge clk or posedge reset) begin
      if (reset)      r_stall_cnt <= 32'd0;
      else if (Stall) r_stall_cnt <= r_stall_cnt + 32'd1;
   end

   assign StallCount = r_stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] RegRead0_ID, RegRead1_ID;
   logic [2:0] Tuse_RAddr0_ID, Tuse_RAddr1_ID;
   logic [4:0] WAddr_EX, WAddr_Mem;
   logic [2:0] Tnew_EX, Tnew_Mem;
   logic       MultTypeInstr, Start, MDDiv;
   logic       Stall, Busy, MDDone;
   logic [1:0] RData0BypassCtrl, RData1BypassCtrl;
`ifdef HAZARD_STALL_CNT_EN
   logic [31:0] StallCount;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      string      tag;
      logic       stall;
      logic [1:0] b0;
      logic [1:0] b1;
      logic       busy;
      logic       done;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   hazard_ctrl dut (
      .clk              (clk),
      .reset            (reset),
      .RegRead0_ID      (RegRead0_ID),
      .RegRead1_ID      (RegRead1_ID),
      .Tuse_RAddr0_ID   (Tuse_RAddr0_ID),
      .Tuse_RAddr1_ID   (Tuse_RAddr1_ID),
      .WAddr_EX         (WAddr_EX),
      .Tnew_EX          (Tnew_EX),
      .WAddr_Mem        (WAddr_Mem),
      .Tnew_Mem         (Tnew_Mem),
      .MultTypeInstr    (MultTypeInstr),
      .Start            (Start),
      .MDDiv            (MDDiv),
      .Stall            (Stall),
      .RData0BypassCtrl (RData0BypassCtrl),
      .RData1BypassCtrl (RData1BypassCtrl),
`ifdef HAZARD_STALL_CNT_EN
      .StallCount       (StallCount),
`endif
      .Busy             (Busy),
      .MDDone           (MDDone)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Push the expectation for the current input vector, then compare it
   // against the DUT at the falling edge and step to just after the next rise.
   task automatic cyc(input string tag, input logic e_stall, input logic [1:0] e_b0,
                      input logic [1:0] e_b1, input logic e_busy, input logic e_done);
      exp_t e;
      exp_q.push_back('{tag, e_stall, e_b0, e_b1, e_busy, e_done});
      @(negedge clk);
      e = exp_q.pop_front();
      check({e.tag, ".stall"}, {31'd0, Stall},  {31'd0, e.stall});
      check({e.tag, ".b0"},    {30'd0, RData0BypassCtrl}, {30'd0, e.b0});
      check({e.tag, ".b1"},    {30'd0, RData1BypassCtrl}, {30'd0, e.b1});
      check({e.tag, ".busy"},  {31'd0, Busy},   {31'd0, e.busy});
      check({e.tag, ".done"},  {31'd0, MDDone}, {31'd0, e.done});
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      RegRead0_ID = 5'd0;  RegRead1_ID = 5'd0;
      Tuse_RAddr0_ID = 3'b111; Tuse_RAddr1_ID = 3'b111;
      WAddr_EX = 5'd0; Tnew_EX = 3'd0;
      WAddr_Mem = 5'd0; Tnew_Mem = 3'd0;
      MultTypeInstr = 1'b0; Start = 1'b0; MDDiv = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      @(posedge clk); #1;
      cyc("rst", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
`ifdef HAZARD_STALL_CNT_EN
      check("rst.cnt", StallCount, 32'd0);
`endif
      reset = 1'b0;
      cyc("post_rst", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);

      // Mult: busy cycles 0-5, done at 5 only, idle at 6
      for (int i = 0; i < 8; i++) begin
         Start = (i == 0); MDDiv = 1'b0;
         cyc($sformatf("mult%0d", i), 1'b0, 2'b00, 2'b00, (i <= 5), (i == 5));
      end

      // Div with a HI/LO user held in ID: stall 11 cycles then release
      for (int i = 0; i < 13; i++) begin
         Start = (i == 0); MDDiv = (i == 0); MultTypeInstr = 1'b1;
         cyc($sformatf("div%0d", i), (i <= 10), 2'b00, 2'b00, (i <= 10), (i == 10));
      end
      MultTypeInstr = 1'b0;

      // Start re-issued mid-RUN as a div must not reload the mult count
      for (int i = 0; i < 7; i++) begin
         Start = (i == 0) || (i == 2); MDDiv = (i == 2);
         cyc($sformatf("ign%0d", i), 1'b0, 2'b00, 2'b00, (i <= 5), (i == 5));
      end
      Start = 1'b0; MDDiv = 1'b0;

      // EX producer not ready -> stall; ready -> bypass from ID/EX
      RegRead0_ID = 5'd8; Tuse_RAddr0_ID = 3'd0; WAddr_EX = 5'd8; Tnew_EX = 3'd1;
      cyc("ex_stall", 1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
      Tnew_EX = 3'd0;
      cyc("ex_fwd", 1'b0, 2'b01, 2'b00, 1'b0, 1'b0);

      // Both stages write r9: EX wins, then Mem once EX stops matching
      idle_inputs();
      RegRead1_ID = 5'd9; Tuse_RAddr1_ID = 3'd0;
      WAddr_EX = 5'd9; WAddr_Mem = 5'd9;
      cyc("prio_ex", 1'b0, 2'b00, 2'b01, 1'b0, 1'b0);
      WAddr_EX = 5'd0;
      cyc("prio_mem", 1'b0, 2'b00, 2'b10, 1'b0, 1'b0);

      // Register 0 is never a hazard
      idle_inputs();
      Tuse_RAddr0_ID = 3'd0; Tnew_EX = 3'd2;
      cyc("r0", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);

      // Mem-stage stall boundary: Tnew_Mem > Tuse stalls, equal does not
      idle_inputs();
      RegRead1_ID = 5'd5; Tuse_RAddr1_ID = 3'd1; WAddr_Mem = 5'd5; Tnew_Mem = 3'd2;
      cyc("mem_gt", 1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
      Tuse_RAddr1_ID = 3'd2;
      cyc("mem_eq", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
      Tuse_RAddr1_ID = 3'b111; Tnew_Mem = 3'd7;
      cyc("mem_unused", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);

      // Reset while a div has counter = 3 (RUN cycle 8)
      idle_inputs();
      for (int i = 0; i < 8; i++) begin
         Start = (i == 0); MDDiv = (i == 0); MultTypeInstr = 1'b1;
         cyc($sformatf("divr%0d", i), 1'b1, 2'b00, 2'b00, 1'b1, 1'b0);
      end
      Start = 1'b0; MultTypeInstr = 1'b0;
      #2 reset = 1'b1;
      cyc("rst_mid", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
`ifdef HAZARD_STALL_CNT_EN
      check("rst_mid.cnt", StallCount, 32'd0);
`endif
      reset = 1'b0;
      cyc("rst_rel", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);

      // Fresh mult after reset behaves normally
      for (int i = 0; i < 7; i++) begin
         Start = (i == 0); MDDiv = 1'b0;
         cyc($sformatf("mult_r%0d", i), 1'b0, 2'b00, 2'b00, (i <= 5), (i == 5));
      end
      Start = 1'b0;

`ifdef HAZARD_STALL_CNT_EN
      // Three data-hazard stall cycles on top of the count since reset (0)
      RegRead0_ID = 5'd3; Tuse_RAddr0_ID = 3'd0; WAddr_EX = 5'd3; Tnew_EX = 3'd2;
      for (int i = 0; i < 3; i++) cyc("cnt_stall", 1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
      idle_inputs();
      cyc("cnt_idle", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
      check("cnt3", StallCount, 32'd3);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
